// File: rtl/reaction_auto_player_if.sv
// Level-based signal bundle between the auto player and the board: game LEDs and
// controls in, switch drive and status out. There is no handshake; every signal is sampled each clock.
interface reaction_auto_player_if;
  logic        enable;
  logic [9:0]  delay_cs;
  logic [9:0]  hold_cs;
  logic [9:0]  led_in;
  logic [9:0]  sw_out;
  logic        busy;
  logic [3:0]  target;
  logic [15:0] hits;
  logic [7:0]  misses;
  logic [2:0]  state_dbg;

  modport master (
    output enable, delay_cs, hold_cs, led_in,
    input  sw_out, busy, target, hits, misses, state_dbg
  );

  modport slave (
    input  enable, delay_cs, hold_cs, led_in,
    output sw_out, busy, target, hits, misses, state_dbg
  );
endinterface

// File: rtl/reaction_auto_player.sv
// Autonomous responder for the reaction game: presses the switch matching a lone lit LED
// after a programmable delay, holds it until the all-LED blink confirms, then lets go.
module reaction_auto_player #(
  parameter int TICK_DIV   = 500000,
  parameter int TIMEOUT_CS = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  reaction_auto_player_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESS   = 3'd3,
    S_HOLD    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic [9:0]    cs_cnt;
  logic [9:0]    delay_q, hold_q;
  logic [3:0]    target_q;
  logic [9:0]    sw_q;
  logic          busy_q;
  logic [15:0]   hits_q;
  logic [7:0]    misses_q;

  logic          tick, one_hot, confirm, timeout;
  logic [3:0]    led_idx;

  always_comb begin
    tick    = (presc == PW'(TICK_DIV - 1));
    one_hot = ($countones(bus.led_in) == 1);
    confirm = (bus.led_in == 10'h3FF);
    // Timeout fires on the tick that brings the cs count up to TIMEOUT_CS.
    timeout = tick && (cs_cnt == 10'(TIMEOUT_CS - 1));
    led_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.led_in[i]) led_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_d = S_ARMED;
        S_ARMED:   if (one_hot) state_d = S_WAIT;
        S_WAIT:    if (cs_cnt == delay_q) state_d = S_PRESS;
        S_PRESS: begin
          if (confirm)      state_d = S_HOLD;
          else if (timeout) state_d = S_RELEASE;
        end
        S_HOLD:    if (cs_cnt == hold_q) state_d = S_RELEASE;
        S_RELEASE: if (tick && bus.led_in == 10'd0) state_d = S_ARMED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      presc    <= '0;
      cs_cnt   <= '0;
      delay_q  <= '0;
      hold_q   <= '0;
      target_q <= '0;
      sw_q     <= '0;
      busy_q   <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state <= state_d;
      // Timebase restarts on every state entry so each timed interval starts from zero.
      if (state_d != state) begin
        presc  <= '0;
        cs_cnt <= '0;
      end else if (tick) begin
        presc  <= '0;
        cs_cnt <= cs_cnt + 10'd1;
      end else begin
        presc  <= presc + PW'(1);
      end

      if (state == S_ARMED && state_d == S_WAIT) begin
        target_q <= led_idx;
        delay_q  <= bus.delay_cs;
      end
      if (state == S_PRESS && state_d == S_HOLD) begin
        hold_q <= bus.hold_cs;
        if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      end
      if (state == S_PRESS && state_d == S_RELEASE && misses_q != 8'hFF)
        misses_q <= misses_q + 8'd1;

      sw_q   <= (state_d == S_PRESS || state_d == S_HOLD) ? (10'd1 << target_q) : 10'd0;
      busy_q <= (state_d == S_WAIT) || (state_d == S_PRESS) ||
                (state_d == S_HOLD) || (state_d == S_RELEASE);
    end
  end

  assign bus.sw_out    = sw_q;
  assign bus.busy      = busy_q;
  assign bus.target    = target_q;
  assign bus.hits      = hits_q;
  assign bus.misses    = misses_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_reaction_auto_player.sv
// Directed bench for reaction_auto_player with TICK_DIV=10, TIMEOUT_CS=5.
module tb_reaction_auto_player;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PRESS   = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  reaction_auto_player_if bus();

  reaction_auto_player #(.TICK_DIV(10), .TIMEOUT_CS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] led;
    logic       exp_wait;
    logic [3:0] exp_target;
  } armed_vec_t;

  armed_vec_t vecs[8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cycles, input string name);
    int k;
    k = 0;
    while (bus.state_dbg !== st && k < max_cycles) begin
      step(1);
      k++;
    end
    check(name, 32'(bus.state_dbg), 32'(st));
  endtask

  // One fast confirmed response from ARMED back to ARMED.
  task automatic confirm_cycle(input logic [9:0] led);
    bus.delay_cs = 10'd0;
    bus.hold_cs  = 10'd0;
    bus.led_in   = led;
    step(1);
    bus.led_in = 10'd0;
    step(1);
    bus.led_in = 10'h3FF;
    step(1);
    step(1);
    bus.led_in = 10'd0;
    wait_state(ST_ARMED, 15, "confirm_cycle_rearm");
  endtask

  initial begin
    logic bad;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{10'h000, 1'b0, 4'd0};
    vecs[1] = '{10'h3FF, 1'b0, 4'd0};
    vecs[2] = '{10'h005, 1'b0, 4'd0};
    vecs[3] = '{10'h300, 1'b0, 4'd0};
    vecs[4] = '{10'h001, 1'b1, 4'd0};
    vecs[5] = '{10'h200, 1'b1, 4'd9};
    vecs[6] = '{10'h3FE, 1'b0, 4'd9};
    vecs[7] = '{10'h040, 1'b1, 4'd6};

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.delay_cs = 10'd3;
    bus.hold_cs  = 10'd2;
    bus.led_in   = 10'd0;
    step(3);
    check("reset_state",  32'(bus.state_dbg), 32'(ST_IDLE));
    check("reset_sw",     32'(bus.sw_out), 32'd0);
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_target", 32'(bus.target), 32'd0);
    check("reset_hits",   32'(bus.hits), 32'd0);
    check("reset_misses", 32'(bus.misses), 32'd0);
    reset = 1'b0;
    step(1);
    bus.enable = 1'b1;
    step(1);
    check("idle_to_armed", 32'(bus.state_dbg), 32'(ST_ARMED));

    // ARMED must only react to a single lit LED
    for (int i = 0; i < 8; i++) begin
      bus.led_in = vecs[i].led;
      step(1);
      check($sformatf("armed_vec%0d_state", i), 32'(bus.state_dbg),
            32'(vecs[i].exp_wait ? ST_WAIT : ST_ARMED));
      check($sformatf("armed_vec%0d_target", i), 32'(bus.target), 32'(vecs[i].exp_target));
      check($sformatf("armed_vec%0d_sw", i), 32'(bus.sw_out), 32'd0);
      check($sformatf("armed_vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_wait));
      bus.led_in = 10'd0;
      if (vecs[i].exp_wait) begin
        bus.enable = 1'b0;
        step(1);
        bus.enable = 1'b1;
        step(1);
      end
    end

    // Detection of LED 4 with delay 3: press lands 31 cycles after the detecting edge
    bus.delay_cs = 10'd3;
    bus.hold_cs  = 10'd2;
    bus.led_in   = 10'h010;
    step(1);
    check("a_detect_state",  32'(bus.state_dbg), 32'(ST_WAIT));
    check("a_detect_target", 32'(bus.target), 32'd4);
    bad = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step(1);
      if (k == 4) bus.led_in = 10'd0;
      if (k < 31 && bus.sw_out !== 10'd0) bad = 1'b1;
      if (k == 30) check("a_still_wait", 32'(bus.state_dbg), 32'(ST_WAIT));
    end
    check("a_no_early_press", 32'(bad), 32'd0);
    check("a_press_sw",    32'(bus.sw_out), 32'h010);
    check("a_press_state", 32'(bus.state_dbg), 32'(ST_PRESS));
    step(3);
    bus.led_in = 10'h3FF;
    step(1);
    check("a_hold_state", 32'(bus.state_dbg), 32'(ST_HOLD));
    check("a_hits",       32'(bus.hits), 32'd1);
    check("a_hold_sw",    32'(bus.sw_out), 32'h010);
    // hold_cs=2: sw stays up for 2*10 cycles, the count match moves to RELEASE one edge later
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if (k == 20) check("a_hold_sw_end", 32'(bus.sw_out), 32'h010);
    end
    check("a_release_sw",    32'(bus.sw_out), 32'd0);
    check("a_release_state", 32'(bus.state_dbg), 32'(ST_RELEASE));
    check("a_release_busy",  32'(bus.busy), 32'd1);
    step(15);
    check("a_release_lit", 32'(bus.state_dbg), 32'(ST_RELEASE));
    bus.led_in = 10'd0;
    step(4);
    check("a_release_pre_tick", 32'(bus.state_dbg), 32'(ST_RELEASE));
    step(1);
    check("a_rearm_state", 32'(bus.state_dbg), 32'(ST_ARMED));
    check("a_rearm_busy",  32'(bus.busy), 32'd0);

    // Delay 0, no confirmation: timeout after 5 ticks in PRESS
    bus.delay_cs = 10'd0;
    bus.led_in   = 10'h002;
    step(1);
    bus.led_in = 10'd0;
    step(1);
    check("b_press_sw", 32'(bus.sw_out), 32'h002);
    bad = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      if (k < 50 && bus.sw_out !== 10'h002) bad = 1'b1;
    end
    check("b_held_full_window", 32'(bad), 32'd0);
    check("b_timeout_sw",     32'(bus.sw_out), 32'd0);
    check("b_timeout_state",  32'(bus.state_dbg), 32'(ST_RELEASE));
    check("b_misses",         32'(bus.misses), 32'd1);
    check("b_hits_unchanged", 32'(bus.hits), 32'd1);
    step(9);
    check("b_release_pre_tick", 32'(bus.state_dbg), 32'(ST_RELEASE));
    step(1);
    check("b_rearm", 32'(bus.state_dbg), 32'(ST_ARMED));

    // Confirmation on the timeout cycle wins; hold 0 lasts one cycle
    bus.hold_cs = 10'd0;
    bus.led_in  = 10'h020;
    step(1);
    bus.led_in = 10'd0;
    step(1);
    step(49);
    bus.led_in = 10'h3FF;
    step(1);
    check("c_tie_state",  32'(bus.state_dbg), 32'(ST_HOLD));
    check("c_tie_hits",   32'(bus.hits), 32'd2);
    check("c_tie_misses", 32'(bus.misses), 32'd1);
    check("c_tie_sw",     32'(bus.sw_out), 32'h020);
    step(1);
    check("c_hold0_state", 32'(bus.state_dbg), 32'(ST_RELEASE));
    check("c_hold0_sw",    32'(bus.sw_out), 32'd0);
    bus.led_in = 10'd0;
    wait_state(ST_ARMED, 15, "c_rearm");

    // Dropping enable during WAIT aborts without a press and keeps the counts
    bus.delay_cs = 10'd2;
    bus.led_in   = 10'h080;
    step(1);
    check("e_target", 32'(bus.target), 32'd7);
    bus.led_in = 10'd0;
    step(3);
    bus.enable = 1'b0;
    step(1);
    check("e_idle_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check("e_idle_busy",  32'(bus.busy), 32'd0);
    check("e_hits_held",   32'(bus.hits), 32'd2);
    check("e_misses_held", 32'(bus.misses), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (bus.sw_out !== 10'd0 || bus.state_dbg !== ST_IDLE) bad = 1'b1;
    end
    check("e_no_press", 32'(bad), 32'd0);

    // hits saturation
    bus.enable = 1'b1;
    step(1);
    force dut.hits_q = 16'hFFFE;
    step(1);
    release dut.hits_q;
    step(1);
    check("f_preload", 32'(bus.hits), 32'hFFFE);
    confirm_cycle(10'h001);
    check("f_hits_top", 32'(bus.hits), 32'hFFFF);
    confirm_cycle(10'h001);
    check("f_hits_sat", 32'(bus.hits), 32'hFFFF);
    check("f_target",   32'(bus.target), 32'd0);

    // Reset in HOLD clears everything without waiting for a clock
    bus.delay_cs = 10'd0;
    bus.hold_cs  = 10'd5;
    bus.led_in   = 10'h100;
    step(1);
    bus.led_in = 10'd0;
    step(1);
    bus.led_in = 10'h3FF;
    step(1);
    check("d_hold_state", 32'(bus.state_dbg), 32'(ST_HOLD));
    check("d_hold_sw",    32'(bus.sw_out), 32'h100);
    step(3);
    #1 reset = 1'b1;
    #1;
    check("d_rst_sw",     32'(bus.sw_out), 32'd0);
    check("d_rst_hits",   32'(bus.hits), 32'd0);
    check("d_rst_misses", 32'(bus.misses), 32'd0);
    check("d_rst_state",  32'(bus.state_dbg), 32'(ST_IDLE));
    check("d_rst_target", 32'(bus.target), 32'd0);
    check("d_rst_busy",   32'(bus.busy), 32'd0);
    bus.led_in = 10'd0;
    step(2);
    reset = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
